mul_div_seq: RTL and testbench
==============================

MUL_DIV_SEQ -- requirements
Module: mul_div_seq

Interface
REQ-001 Parameters SHALL be:
  - XLEN, default 32, operand/result width (even, >=8).
  - CNT_W, default $clog2(XLEN)+1, iteration counter width.
REQ-002 Ports SHALL be:
  - iCLK  in  1  single clock; all state updates on rising edge.
  - iRST  in  1  reset; synchronous, active-high.
  - iStart  in  1  request; accepted only on an edge where oReady=1.
  - iFunct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - iA  in  XLEN  rs1 operand.
  - iB  in  XLEN  rs2 operand.
  - iFlush  in  1  abort of any in-flight operation.
  - oReady  out  1  FSM in IDLE.
  - oBusy  out  1  equals ~oReady; drives datapath PC stall.
  - oDone  out  1  one-cycle result-valid pulse.
  - oResult  out  XLEN  last completed result, held until next completion.

Function
REQ-003 The FSM SHALL have states IDLE, CALC, FIX, DONE.
REQ-004 IDLE -> CALC on iStart=1 and iFlush=0; accept edge latches funct3, |iA|, |iB|, result-sign and remainder-sign flags.
REQ-005 Signedness SHALL be:
  - MULH: both operands signed.
  - MULHSU: iA signed, iB unsigned.
  - DIV/REM: both signed.
  - All other ops: unsigned.
REQ-006 CALC SHALL last exactly XLEN cycles, with a counter loaded to XLEN-1 that decrements to 0, then -> FIX.
  - Multiply: one shift-add step per cycle into a 2*XLEN accumulator.
  - Divide: one restoring step per cycle.
REQ-007 FIX SHALL take one cycle: conditional two's-complement negation, then selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits.
  - DIV, DIVU: quotient.
  - REM, REMU: remainder, whose sign follows the dividend.
  - Next state DONE.
REQ-008 DONE SHALL register oResult, assert oDone for exactly that one cycle, and return to IDLE.
REQ-009 Normal latency: oDone=1 in the cycle following edge N+XLEN+2, where N is the accept edge.
REQ-010 On divide-by-zero (iB=0, funct3[2]=1) the FSM SHALL bypass CALC: IDLE -> FIX -> DONE, so oDone is high after edge N+2. Results:
  - DIV, DIVU: all ones.
  - REM, REMU: iA.
REQ-011 On signed overflow (DIV/REM with iA = 1<<(XLEN-1) and iB = all ones) the same bypass SHALL apply, with DIV = iA and REM = 0.
REQ-012 iStart while oReady=0 SHALL be ignored; there is no queuing.
REQ-013 iFlush=1 in any state SHALL force IDLE on the next edge, with no oDone and oResult unchanged.
REQ-014 If iFlush and iStart are both 1 in IDLE, flush SHALL win and nothing is accepted.
REQ-015 iA, iB and iFunct3 SHALL be don't-care except on the accept edge.
REQ-016 A new iStart SHALL be accepted in the IDLE cycle immediately following DONE, giving a back-to-back throughput of one op per XLEN+3 cycles.

Reset
REQ-017 Reset SHALL act on the edge where iRST=1 and override iStart and iFlush. It SHALL set:
  - state = IDLE, counter = 0, accumulators = 0.
  - oResult = 0, oDone = 0, oReady = 1, oBusy = 0.
REQ-018 Reset during CALC/FIX/DONE SHALL abort the operation with no oDone pulse.

Structure
REQ-019 The shared package SHALL hold:
  - M-extension funct3 constants (FUNCT3_MUL .. FUNCT3_REMU).
  - State encoding.
  - The RV32M opcode value used by the decoder to raise iStart.
REQ-020 One combinational sub-module, md_sign_fix, SHALL perform the conditional negation and result select of REQ-007; everything else lives in mul_div_seq.

Verification (XLEN=32)
REQ-021 Benches SHALL cover:
  - MUL, iA=7, iB=0xFFFFFFFD -> oResult 0xFFFFFFEB, oDone exactly 34 edges after accept, single-cycle pulse.
  - MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
  - DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with oDone 2 edges after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
  - Flush 10 cycles into CALC -> oReady=1 next edge, no oDone, oResult keeps previous 0x0000000E; iStart held high through busy period is ignored; following MUL 3x4 -> 12.
  - iRST pulse mid-CALC -> IDLE next edge, oResult=0, no oDone; simultaneous iFlush+iStart in IDLE -> no accept, oBusy stays 0.

Source files
------------

// File: rtl/mul_div_seq_pkg.sv
// Shared constants for the RV32M sequential multiply/divide unit:
// funct3 op codes, FSM state encoding and operand signedness helpers.
package mul_div_seq_pkg;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  // The decoder raises iStart for OP-class instructions carrying the MULDIV funct7
  localparam logic [6:0] OPCODE_RV32M  = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  function automatic logic op_signed_a(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_MULHSU) ||
           (funct3 == FUNCT3_DIV)  || (funct3 == FUNCT3_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] funct3);
    return (funct3 == FUNCT3_MULH) || (funct3 == FUNCT3_DIV) ||
           (funct3 == FUNCT3_REM);
  endfunction

endpackage

// File: rtl/mul_div_seq_if.sv
// Request/response bundle between the issuing pipeline (master) and the
// multiply/divide unit (slave).
interface mul_div_seq_if #(
  parameter int XLEN = 32
);

  logic            iStart;
  logic [2:0]      iFunct3;
  logic [XLEN-1:0] iA;
  logic [XLEN-1:0] iB;
  logic            iFlush;
  logic            oReady;
  logic            oBusy;
  logic            oDone;
  logic [XLEN-1:0] oResult;

  modport master (
    output iStart, iFunct3, iA, iB, iFlush,
    input  oReady, oBusy, oDone, oResult
  );

  modport slave (
    input  iStart, iFunct3, iA, iB, iFlush,
    output oReady, oBusy, oDone, oResult
  );

endinterface

// File: rtl/mul_div_seq_sign_fix.sv
// Combinational result stage: restores the sign of the magnitude result and
// picks the product half, quotient or remainder for the latched op.
module md_sign_fix
  import mul_div_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [2*XLEN-1:0] acc,
  input  logic              neg_res,
  input  logic              neg_rem,
  output logic [XLEN-1:0]   result
);

  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;

  // For divides the accumulator holds {remainder, quotient}; for multiplies the full product
  always_comb begin
    product   = neg_res ? -acc : acc;
    quotient  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remainder = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result    = '0;
    case (funct3)
      FUNCT3_MUL:                               result = product[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: result = product[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                  result = quotient;
      default:                                  result = remainder;
    endcase
  end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential RV32M multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with sign fix-up at the end.
module mul_div_seq
  import mul_div_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic          iCLK,
  input logic          iRST,
  mul_div_seq_if.slave bus
);

  localparam logic [XLEN-1:0]  SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(XLEN - 1);

  md_state_e         state;
  md_state_e         state_next;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        funct3_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   opb;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic [XLEN-1:0]   fix_result;
  logic [XLEN-1:0]   fix_q;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              accept;
  logic              step_en;
  logic              fix_en;
  logic              done_en;

  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic              div_zero;
  logic              div_ovf;
  logic              bypass;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_diff;

  // Operand decode, only meaningful on the accept edge
  always_comb begin
    sign_a   = op_signed_a(bus.iFunct3) & bus.iA[XLEN-1];
    sign_b   = op_signed_b(bus.iFunct3) & bus.iB[XLEN-1];
    abs_a    = sign_a ? -bus.iA : bus.iA;
    abs_b    = sign_b ? -bus.iB : bus.iB;
    div_zero = bus.iFunct3[2] && (bus.iB == '0);
    div_ovf  = bus.iFunct3[2] && !bus.iFunct3[0] &&
               (bus.iA == SIGNED_MIN) && (bus.iB == '1);
    bypass   = div_zero | div_ovf;
  end

  // One iteration: multiply adds into the upper half and shifts right,
  // divide shifts the remainder left and keeps the trial subtraction if it fits
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : '0)};
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opb};
    acc_step = {mul_sum, acc[XLEN-1:1]};
    if (funct3_q[2]) begin
      acc_step = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.iFlush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (bus.iStart) state_next = bypass ? ST_FIX : ST_CALC;
        ST_CALC: if (cnt == '0)  state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.oReady = (state == ST_IDLE);
    bus.oBusy  = (state != ST_IDLE);
    accept     = (state == ST_IDLE) && bus.iStart && !bus.iFlush;
    step_en    = (state == ST_CALC) && !bus.iFlush;
    fix_en     = (state == ST_FIX)  && !bus.iFlush;
    done_en    = (state == ST_DONE) && !bus.iFlush;
  end

  // Special divides preload the accumulator so the normal fix-up yields the architected answer
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      cnt       <= '0;
      funct3_q  <= '0;
      acc       <= '0;
      opb       <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      fix_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= done_en;
      if (accept) begin
        funct3_q <= bus.iFunct3;
        cnt      <= CNT_LOAD;
        opb      <= abs_b;
        if (div_zero) begin
          acc       <= {bus.iA, {XLEN{1'b1}}};
          neg_res_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else if (div_ovf) begin
          acc       <= {{XLEN{1'b0}}, SIGNED_MIN};
          neg_res_q <= 1'b0;
          neg_rem_q <= 1'b0;
        end else begin
          acc       <= {{XLEN{1'b0}}, abs_a};
          neg_res_q <= sign_a ^ sign_b;
          neg_rem_q <= sign_a;
        end
      end
      if (step_en) begin
        acc <= acc_step;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
      if (fix_en)  fix_q    <= fix_result;
      if (done_en) result_q <= fix_q;
    end
  end

  md_sign_fix #(
    .XLEN(XLEN)
  ) u_sign_fix (
    .funct3 (funct3_q),
    .acc    (acc),
    .neg_res(neg_res_q),
    .neg_rem(neg_rem_q),
    .result (fix_result)
  );

  assign bus.oDone   = done_q;
  assign bus.oResult = result_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed bench for mul_div_seq at XLEN=32: hand-computed results, latency,
// flush, reset and start-while-busy behaviour.
module tb_mul_div_seq;
  import mul_div_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  mul_div_seq_if #(.XLEN(32)) bus ();

  mul_div_seq #(
    .XLEN(32)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs are scrambled after the accept edge since they must be latched there
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] b);
    bus.iFunct3 = f3;
    bus.iA      = a;
    bus.iB      = b;
    bus.iStart  = 1'b1;
    step();
    bus.iStart  = 1'b0;
    bus.iFunct3 = ~f3;
    bus.iA      = 32'hDEAD_BEEF;
    bus.iB      = 32'h1234_5678;
  endtask

  task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat);
    int cycles = 0;
    applyStimulus(f3, a, b);
    while (bus.oDone !== 1'b1 && cycles < 100) begin
      step();
      cycles++;
    end
    checkOutput({tag, " latency"}, cycles, exp_lat);
    checkOutput({tag, " result"}, bus.oResult, exp_res);
    checkOutput({tag, " ready"}, {31'd0, bus.oReady}, 32'd1);
    step();
    checkOutput({tag, " pulse"}, {31'd0, bus.oDone}, 32'd0);
  endtask

  initial begin
    logic bad;
    bus.iStart  = 1'b0;
    bus.iFunct3 = 3'b000;
    bus.iA      = '0;
    bus.iB      = '0;
    bus.iFlush  = 1'b0;
    step();
    step();
    checkOutput("reset ready",  {31'd0, bus.oReady}, 32'd1);
    checkOutput("reset busy",   {31'd0, bus.oBusy},  32'd0);
    checkOutput("reset done",   {31'd0, bus.oDone},  32'd0);
    checkOutput("reset result", bus.oResult, 32'd0);
    rst = 1'b0;
    step();

    runOp("mul",      FUNCT3_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    runOp("mulh",     FUNCT3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    runOp("mulhu",    FUNCT3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    runOp("mulhsu",   FUNCT3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    runOp("div neg",  FUNCT3_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    runOp("rem neg",  FUNCT3_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    runOp("remu",     FUNCT3_REMU,   32'd100,       32'd7,         32'd2,         34);
    runOp("divu by0", FUNCT3_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 2);
    runOp("rem by0",  FUNCT3_REM,    32'd5,         32'd0,         32'd5,         2);
    runOp("div ovf",  FUNCT3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    runOp("rem ovf",  FUNCT3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);
    runOp("divu",     FUNCT3_DIVU,   32'd100,       32'd7,         32'd14,        34);

    // Flush ten cycles into CALC
    applyStimulus(FUNCT3_MULHU, 32'hFFFF_0000, 32'h0000_FFFF);
    repeat (10) step();
    bus.iFlush = 1'b1;
    step();
    bus.iFlush = 1'b0;
    checkOutput("flush ready",  {31'd0, bus.oReady}, 32'd1);
    checkOutput("flush done",   {31'd0, bus.oDone},  32'd0);
    checkOutput("flush result", bus.oResult, 32'h0000_000E);
    bad = 1'b0;
    repeat (40) begin
      step();
      if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) bad = 1'b1;
    end
    checkOutput("flush quiet", {31'd0, bad}, 32'd0);

    // iStart held high with other operands while busy must not disturb MUL 3x4
    bus.iFunct3 = FUNCT3_MUL;
    bus.iA      = 32'd3;
    bus.iB      = 32'd4;
    bus.iStart  = 1'b1;
    step();
    bus.iFunct3 = FUNCT3_DIVU;
    bus.iA      = 32'd5;
    bus.iB      = 32'd9;
    bad = 1'b0;
    repeat (33) begin
      step();
      if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b1) bad = 1'b1;
    end
    bus.iStart = 1'b0;
    checkOutput("held busy", {31'd0, bad}, 32'd0);
    step();
    checkOutput("held done",   {31'd0, bus.oDone}, 32'd1);
    checkOutput("held result", bus.oResult, 32'd12);
    step();
    checkOutput("held pulse", {31'd0, bus.oDone}, 32'd0);
    checkOutput("held idle",  {31'd0, bus.oBusy}, 32'd0);

    // Reset pulse mid-CALC
    applyStimulus(FUNCT3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst ready",  {31'd0, bus.oReady}, 32'd1);
    checkOutput("rst result", bus.oResult, 32'd0);
    checkOutput("rst done",   {31'd0, bus.oDone}, 32'd0);
    bad = 1'b0;
    repeat (40) begin
      step();
      if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) bad = 1'b1;
    end
    checkOutput("rst quiet", {31'd0, bad}, 32'd0);

    // Flush wins over a simultaneous start in IDLE
    bus.iFunct3 = FUNCT3_MUL;
    bus.iA      = 32'd6;
    bus.iB      = 32'd7;
    bus.iStart  = 1'b1;
    bus.iFlush  = 1'b1;
    step();
    bus.iStart  = 1'b0;
    bus.iFlush  = 1'b0;
    checkOutput("flush+start busy", {31'd0, bus.oBusy}, 32'd0);
    step();
    checkOutput("flush+start idle", {31'd0, bus.oBusy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
